// File: rtl/mcc_adder_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mcc_adder_pipe_pkg : shared defaults and helpers for the pipelined   |
// | Manchester-carry adder.                      Revision: 1.0           |
// +--------------------------------------------------------------------+
package mcc_adder_pipe_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BLK   = 4;
    localparam int DEF_SLICE = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int nstage(input int width, input int slice);
        return width / slice;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcc_adder_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mcc_adder_pipe_if : operand/result handshake bundle.                 |
// |                                              Revision: 1.0           |
// +--------------------------------------------------------------------+
interface mcc_adder_pipe_if
    import mcc_adder_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/mcc_slice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mcc_slice : combinational SLICE-bit slice of BLK-bit Manchester      |
// | carry groups.                                Revision: 1.0           |
// +--------------------------------------------------------------------+
module mcc_slice #(
    parameter int SLICE = 4,
    parameter int BLK   = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             cmsb
);
    localparam int NGRP = SLICE / BLK;

    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic             carry;

    assign p = a ^ b;
    assign g = a & b;

    // Carry walks each group's chain in turn; cmsb taps the carry entering the top bit.
    always_comb begin
        carry = ci;
        s     = '0;
        cmsb  = 1'b0;
        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < BLK; i++) begin
                if (j * BLK + i == SLICE - 1) begin
                    cmsb = carry;
                end
                s[j*BLK+i] = p[j*BLK+i] ^ carry;
                carry      = g[j*BLK+i] | (p[j*BLK+i] & carry);
            end
        end
        co = carry;
    end
endmodule
`default_nettype wire

// File: rtl/mcc_adder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mcc_adder_pipe : skewed pipelined add/sub, one slice per stage,      |
// | bubble-collapsing valid/ready.               Revision: 1.0           |
// +--------------------------------------------------------------------+
module mcc_adder_pipe
    import mcc_adder_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK,
    parameter int SLICE = DEF_SLICE
) (
    input  logic            clk,
    input  logic            rst_n,
    mcc_adder_pipe_if.slave bus
);
    localparam int NSTAGE = nstage(WIDTH, SLICE);

    if ((WIDTH % SLICE) != 0 || (SLICE % BLK) != 0 || NSTAGE < 2) begin : g_param_check
        $error("mcc_adder_pipe: WIDTH/SLICE/BLK combination not supported");
    end

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [NSTAGE:1]  v;
    logic [NSTAGE:1]  rdy;
    logic [WIDTH-1:0] s_q [1:NSTAGE];
    logic             c_q [1:NSTAGE];
    logic [WIDTH-1:0] a_q [1:NSTAGE-1];
    logic [WIDTH-1:0] b_q [1:NSTAGE-1];
    logic             ovf_q;

    assign b_eff = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
    assign c0    = bus.cin ^ bus.sub;

    // A stage may advance if the one after it advances or it holds no beat.
    always_comb begin
        rdy[NSTAGE] = bus.out_ready | ~v[NSTAGE];
        for (int k = NSTAGE - 1; k >= 1; k--) begin
            rdy[k] = rdy[k+1] | ~v[k];
        end
    end

    for (genvar k = 1; k <= NSTAGE; k++) begin : g_stg
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_nxt;
        logic             c_in;
        logic             v_in;
        logic [SLICE-1:0] sl_sum;
        logic             sl_co;
        logic             sl_cmsb;

        if (k == 1) begin : g_first
            assign a_in = bus.a;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = c0;
            assign v_in = bus.in_valid;
        end else begin : g_next
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign s_in = s_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = v[k-1];
        end

        mcc_slice #(
            .SLICE (SLICE),
            .BLK   (BLK)
        ) u_slice (
            .a    (a_in[(k-1)*SLICE +: SLICE]),
            .b    (b_in[(k-1)*SLICE +: SLICE]),
            .ci   (c_in),
            .s    (sl_sum),
            .co   (sl_co),
            .cmsb (sl_cmsb)
        );

        always_comb begin
            s_nxt                          = s_in;
            s_nxt[(k-1)*SLICE +: SLICE]    = sl_sum;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v[k]   <= 1'b0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (rdy[k]) begin
                v[k]   <= v_in;
                s_q[k] <= s_nxt;
                c_q[k] <= sl_co;
            end
        end

        if (k < NSTAGE) begin : g_ops
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                end else if (rdy[k]) begin
                    a_q[k] <= a_in;
                    b_q[k] <= b_in;
                end
            end
        end else begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (rdy[k]) begin
                    ovf_q <= sl_cmsb ^ sl_co;
                end
            end
        end
    end

    assign bus.in_ready  = rdy[1];
    assign bus.out_valid = v[NSTAGE];
    assign bus.sum       = s_q[NSTAGE];
    assign bus.cout      = c_q[NSTAGE];
    assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire
